counter_run_ctrl: RTL and testbench

//  Sequencer for a WIDTH-bit binary counter datapath: programmable start/end values,
//  up/down direction, one-shot or auto-reload, start/stop control, terminal-count flag.

---
 rtl/counter_run_ctrl_pkg.sv | 17 +
 rtl/count_reg_updown.sv | 47 ++++
 rtl/counter_run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_counter_run_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_run_ctrl_pkg.sv
// Shared types and constants for the counter run controller.
package counter_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/count_reg_updown.sv
// WIDTH-bit up/down count register with synchronous load and enable.
// Load has priority over enable; the count wraps modulo 2**WIDTH.
module count_reg_updown
  import counter_run_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Choose the next count: load wins, otherwise step in the requested direction.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (dir_i == DIR_UP) begin
        count_d = count_q + ONE;
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_run_ctrl.sv
// Run sequencer for an up/down counter: captures the run settings on start,
// loads the start value, steps until the terminal value, then either finishes
// (one-shot) or reloads (auto-reload). Stop aborts and freezes the count.
// Optional feature macro: COUNTER_RUN_CTRL_PRESCALER_EN adds presc_div, which
// slows RUN stepping to one tick every presc_div+1 clocks.
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
`ifdef COUNTER_RUN_CTRL_PRESCALER_EN
  input  logic [3:0]       presc_div,
`endif
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] end_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t state_q;
  state_t state_d;

  logic             dirCap_q;
  logic             modeCap_q;
  logic [WIDTH-1:0] loadCap_q;
  logic [WIDTH-1:0] endCap_q;

  logic             tc_q;
  logic             tc_d;

  logic             capture;
  logic             cntLoad;
  logic             cntEn;
  logic             tick;
  logic [WIDTH-1:0] countVal;

`ifdef COUNTER_RUN_CTRL_PRESCALER_EN
  logic [3:0] prescDiv_q;
  logic [3:0] prescCnt_q;
  logic [3:0] prescCnt_d;

  assign tick = (prescCnt_q == prescDiv_q);

  // Prescaler advances only while running; any other state or a stop clears it,
  // so every RUN entry begins a full period.
  always_comb begin
    prescCnt_d = 4'd0;
    if (state_q == RUN && !stop) begin
      prescCnt_d = tick ? 4'd0 : prescCnt_q + 4'd1;
    end
  end

  // Prescaler divider capture and running count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescDiv_q <= 4'd0;
      prescCnt_q <= 4'd0;
    end else begin
      if (capture) begin
        prescDiv_q <= presc_div;
      end
      prescCnt_q <= prescCnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state and counter control; stop beats both start and a terminal match.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    cntLoad = 1'b0;
    cntEn   = 1'b0;
    tc_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          capture = 1'b1;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          cntLoad = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          if (countVal == endCap_q) begin
            tc_d = 1'b1;
            if (modeCap_q == MODE_RELOAD) begin
              cntLoad = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            cntEn = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, terminal-count pulse and run settings captured on an accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tc_q      <= 1'b0;
      dirCap_q  <= 1'b0;
      modeCap_q <= 1'b0;
      loadCap_q <= '0;
      endCap_q  <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      if (capture) begin
        dirCap_q  <= dir;
        modeCap_q <= mode;
        loadCap_q <= load_val;
        endCap_q  <= end_val;
      end
    end
  end

  count_reg_updown #(
    .WIDTH(WIDTH)
  ) u_count (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cntLoad),
    .en_i       (cntEn),
    .dir_i      (dirCap_q),
    .load_val_i (loadCap_q),
    .count_o    (countVal)
  );

  assign count = countVal;
  assign busy  = (state_q == LOAD) || (state_q == RUN);
  assign tc    = tc_q;
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed self-checking bench for counter_run_ctrl (WIDTH=4).
// Prescaler scenarios run only when COUNTER_RUN_CTRL_PRESCALER_EN is defined.
module tb_counter_run_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       dir;
  logic       mode;
  logic [3:0] load_val;
  logic [3:0] end_val;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;
`ifdef COUNTER_RUN_CTRL_PRESCALER_EN
  logic [3:0] presc_div;
`endif

  int checkCount;
  int errorCount;

  counter_run_ctrl #(
    .WIDTH(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .mode     (mode),
`ifdef COUNTER_RUN_CTRL_PRESCALER_EN
    .presc_div(presc_div),
`endif
    .load_val (load_val),
    .end_val  (end_val),
    .count    (count),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive the control inputs for the next edge.
  task automatic applyStimulus(input logic s, input logic p, input logic d, input logic m,
                               input logic [3:0] lv, input logic [3:0] ev);
    start    = s;
    stop     = p;
    dir      = d;
    mode     = m;
    load_val = lv;
    end_val  = ev;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic stepClk();
    @(posedge clock);
    #1;
  endtask

  // Check all four outputs at once.
  task automatic checkAll(input string tag, input int c, input int b, input int t, input int d);
    checkOutput({tag, ".count"}, int'(count), c);
    checkOutput({tag, ".busy"},  int'(busy),  b);
    checkOutput({tag, ".tc"},    int'(tc),    t);
    checkOutput({tag, ".done"},  int'(done),  d);
  endtask

  // Issue a start pulse sampled at the next edge (edge 0 of the run).
  task automatic startRun(input logic d, input logic m, input logic [3:0] lv, input logic [3:0] ev);
    applyStimulus(1'b1, 1'b0, d, m, lv, ev);
    stepClk();
    applyStimulus(1'b0, 1'b0, d, m, lv, ev);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
`ifdef COUNTER_RUN_CTRL_PRESCALER_EN
    presc_div = 4'd0;
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    stepClk();
    stepClk();
    checkAll("reset", 0, 0, 0, 0);
    reset = 1'b0;
    stepClk();
    checkAll("idle", 0, 0, 0, 0);

    // Up, one-shot: 3,4,5,6 then tc+done, then idle.
    $display("[TB] up one-shot");
    startRun(1'b1, 1'b0, 4'd3, 4'd6);
    checkOutput("up.load_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      stepClk();
      checkAll($sformatf("up.e%0d", i + 1), 3 + i, 1, 0, 0);
    end
    stepClk();
    checkAll("up.e5", 6, 0, 1, 1);
    stepClk();
    checkAll("up.e6", 6, 0, 0, 0);

    // Down with wrap: 1,0,15,14 then tc+done.
    $display("[TB] down wrap");
    startRun(1'b0, 1'b0, 4'd1, 4'd14);
    stepClk(); checkOutput("down.e1", int'(count), 1);
    stepClk(); checkOutput("down.e2", int'(count), 0);
    stepClk(); checkOutput("down.e3", int'(count), 15);
    stepClk(); checkAll("down.e4", 14, 1, 0, 0);
    stepClk(); checkAll("down.e5", 14, 0, 1, 1);
    stepClk();

    // Auto-reload: 2,3,4,2,3,4,2 with tc after each reload, never done.
    $display("[TB] auto-reload");
    startRun(1'b1, 1'b1, 4'd2, 4'd4);
    stepClk(); checkAll("rel.e1", 2, 1, 0, 0);
    stepClk(); checkAll("rel.e2", 3, 1, 0, 0);
    stepClk(); checkAll("rel.e3", 4, 1, 0, 0);
    stepClk(); checkAll("rel.e4", 2, 1, 1, 0);
    stepClk(); checkAll("rel.e5", 3, 1, 0, 0);
    stepClk(); checkAll("rel.e6", 4, 1, 0, 0);
    stepClk(); checkAll("rel.e7", 2, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd4);
    stepClk(); checkAll("rel.stop", 2, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // Stop mid-run at count 5; count freezes, no tc/done.
    $display("[TB] stop mid-run");
    startRun(1'b1, 1'b0, 4'd0, 4'd9);
    for (int i = 0; i < 6; i++) stepClk();
    checkAll("stop.pre", 5, 1, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
    stepClk(); checkAll("stop.e1", 5, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
    stepClk(); checkAll("stop.e2", 5, 0, 0, 0);

    // start and stop together in IDLE: stop wins.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 4'd9);
    stepClk(); checkAll("startstop.e1", 5, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd9);
    stepClk(); checkAll("startstop.e2", 5, 0, 0, 0);

    // Stop during LOAD: back to IDLE, count not loaded.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd11, 4'd12);
    stepClk();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd11, 4'd12);
    stepClk(); checkAll("loadstop", 5, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // load == end: tc on the first RUN tick.
    $display("[TB] load equals end");
    startRun(1'b1, 1'b0, 4'd5, 4'd5);
    stepClk(); checkAll("eq.e1", 5, 1, 0, 0);
    stepClk(); checkAll("eq.e2", 5, 0, 1, 1);
    stepClk();

    // Start while busy is ignored, then asynchronous reset mid-run at count 9.
    $display("[TB] busy start and reset");
    startRun(1'b1, 1'b0, 4'd7, 4'd12);
    stepClk(); checkOutput("rst.e1", int'(count), 7);
    stepClk(); checkOutput("rst.e2", int'(count), 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
    stepClk(); checkAll("rst.busystart", 9, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    checkAll("rst.async", 0, 0, 0, 0);
    stepClk();
    reset = 1'b0;
    stepClk(); checkAll("rst.after", 0, 0, 0, 0);

`ifdef COUNTER_RUN_CTRL_PRESCALER_EN
    // Prescaler 2: one step every 3 clocks, tc 9 clocks after RUN entry.
    $display("[TB] prescaler");
    presc_div = 4'd2;
    startRun(1'b1, 1'b0, 4'd0, 4'd2);
    stepClk(); checkOutput("presc.e1", int'(count), 0);
    stepClk(); stepClk();
    checkOutput("presc.e3", int'(count), 0);
    stepClk(); checkOutput("presc.e4", int'(count), 1);
    stepClk(); stepClk();
    checkOutput("presc.e6", int'(count), 1);
    stepClk(); checkOutput("presc.e7", int'(count), 2);
    stepClk(); stepClk();
    checkAll("presc.e9", 2, 1, 0, 0);
    stepClk(); checkAll("presc.e10", 2, 0, 1, 1);
    stepClk();

    // Prescaler with load == end: tc on the first tick.
    startRun(1'b1, 1'b0, 4'd5, 4'd5);
    stepClk(); stepClk(); stepClk();
    checkAll("presceq.e3", 5, 1, 0, 0);
    stepClk(); checkAll("presceq.e4", 5, 0, 1, 1);
    stepClk();
    presc_div = 4'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
